// File: rtl/awg_pkg.sv
// Shared widths, limits and field-select encoding for the AWG front-panel
// parameter controller.
package awg_pkg;

   localparam int FREQ_W  = 12;
   localparam int AMP_W   = 3;
   localparam int PHASE_W = 8;
   localparam int DAC_W   = 14;

   localparam logic [AMP_W-1:0]  AMP_MIN  = 3'd1;
   localparam logic [AMP_W-1:0]  AMP_MAX  = 3'd7;
   localparam logic [FREQ_W-1:0] FREQ_MAX = '1;

   typedef enum logic [1:0] {
      SEL_FREQ  = 2'd0,
      SEL_AMP   = 2'd1,
      SEL_PHASE = 2'd2
   } sel_e;

endpackage

// File: rtl/awg_param_ctrl_key_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (debounced 1->0).
module key_debounce #(
   parameter int unsigned DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic press_o
);

   localparam int unsigned          CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      // Any cycle where the synced level agrees with the accepted level restarts the count.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            press_d = ~sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= key_n_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/awg_param_ctrl.sv
// Front-panel controller: debounced keys edit en/freq/amp/phase through a
// field-select FSM; all outputs registered and always within legal range.
module awg_param_ctrl
   import awg_pkg::*;
#(
   parameter int unsigned         DEB_CYCLES = 500000,
   parameter logic [FREQ_W-1:0]   FREQ_STEP  = 12'd16,
   parameter logic [FREQ_W-1:0]   FREQ_MIN   = 12'd1,
   parameter logic [FREQ_W-1:0]   FREQ_RST   = 12'd64,
   parameter logic [AMP_W-1:0]    AMP_RST    = 3'd1,
   parameter logic [PHASE_W-1:0]  PHASE_RST  = 8'd0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_sel_n,
   input  logic               key_up_n,
   input  logic               key_dn_n,
   input  logic               key_en_n,
   output logic               en,
   output logic [FREQ_W-1:0]  freq,
   output logic [AMP_W-1:0]   amp,
   output logic [PHASE_W-1:0] phase,
   output logic [1:0]         sel,
   output logic               upd
);

   logic sel_p, up_p, dn_p, en_p;

   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
      .clk(clk), .rst_n(rst_n), .key_n_i(key_sel_n), .press_o(sel_p));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
      .clk(clk), .rst_n(rst_n), .key_n_i(key_up_n), .press_o(up_p));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
      .clk(clk), .rst_n(rst_n), .key_n_i(key_dn_n), .press_o(dn_p));
   key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_en (
      .clk(clk), .rst_n(rst_n), .key_n_i(key_en_n), .press_o(en_p));

   sel_e               sel_q, sel_d;
   logic               en_q, en_d;
   logic [FREQ_W-1:0]  freq_q, freq_d;
   logic [AMP_W-1:0]   amp_q, amp_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               chg_q, chg_d;
   logic               upd_q;

   logic                     edit_up, edit_dn;
   logic [FREQ_W:0]          freq_up;
   logic signed [FREQ_W:0]   freq_dn;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= SEL_FREQ;
      end else begin
         sel_q <= sel_d;
      end
   end

   always_comb begin
      sel_d = sel_q;
      case (sel_q)
         SEL_FREQ:  if (sel_p) sel_d = SEL_AMP;
         SEL_AMP:   if (sel_p) sel_d = SEL_PHASE;
         SEL_PHASE: if (sel_p) sel_d = SEL_FREQ;
         default:   sel_d = SEL_FREQ;
      endcase
   end

   // A sel press swallows any up/dn in the same cycle; up+dn together cancel.
   assign edit_up = up_p & ~dn_p & ~sel_p;
   assign edit_dn = dn_p & ~up_p & ~sel_p;

   assign freq_up = {1'b0, freq_q} + {1'b0, FREQ_STEP};
   assign freq_dn = $signed({1'b0, freq_q}) - $signed({1'b0, FREQ_STEP});

   always_comb begin
      en_d    = en_q ^ en_p;
      freq_d  = freq_q;
      amp_d   = amp_q;
      phase_d = phase_q;
      case (sel_q)
         SEL_FREQ: begin
            if (edit_up) begin
               freq_d = freq_up[FREQ_W] ? FREQ_MAX : freq_up[FREQ_W-1:0];
            end else if (edit_dn) begin
               freq_d = (freq_dn < $signed({1'b0, FREQ_MIN})) ? FREQ_MIN : freq_dn[FREQ_W-1:0];
            end
         end
         SEL_AMP: begin
            if (edit_up && (amp_q < AMP_MAX)) begin
               amp_d = amp_q + 1'b1;
            end else if (edit_dn && (amp_q > AMP_MIN)) begin
               amp_d = amp_q - 1'b1;
            end
         end
         SEL_PHASE: begin
            if (edit_up) begin
               phase_d = phase_q + 1'b1;
            end else if (edit_dn) begin
               phase_d = phase_q - 1'b1;
            end
         end
         default: ;
      endcase
      chg_d = (en_d != en_q) || (freq_d != freq_q) || (amp_d != amp_q) ||
              (phase_d != phase_q) || (sel_d != sel_q);
   end

   // chg_q marks the cycle the registers moved; upd trails it by one more cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q    <= 1'b0;
         freq_q  <= FREQ_RST;
         amp_q   <= AMP_RST;
         phase_q <= PHASE_RST;
         chg_q   <= 1'b0;
         upd_q   <= 1'b0;
      end else begin
         en_q    <= en_d;
         freq_q  <= freq_d;
         amp_q   <= amp_d;
         phase_q <= phase_d;
         chg_q   <= chg_d;
         upd_q   <= chg_q;
      end
   end

   assign en    = en_q;
   assign freq  = freq_q;
   assign amp   = amp_q;
   assign phase = phase_q;
   assign sel   = sel_q;
   assign upd   = upd_q;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// Directed bench for awg_param_ctrl with a 4-cycle debounce window.
module tb_awg_param_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_sel_n = 1'b1;
   logic        key_up_n  = 1'b1;
   logic        key_dn_n  = 1'b1;
   logic        key_en_n  = 1'b1;
   logic        en;
   logic [11:0] freq;
   logic [2:0]  amp;
   logic [7:0]  phase;
   logic [1:0]  sel;
   logic        upd;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          upd_cnt = 0;
   int          u0;

   always #5 clk = ~clk;

   awg_param_ctrl #(.DEB_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_sel_n(key_sel_n), .key_up_n(key_up_n),
      .key_dn_n(key_dn_n), .key_en_n(key_en_n),
      .en(en), .freq(freq), .amp(amp), .phase(phase), .sel(sel), .upd(upd)
   );

   always @(posedge clk) begin
      if (upd === 1'b1) upd_cnt <= upd_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // m bits: 0=sel 1=up 2=dn 3=en
   task automatic drive(input logic [3:0] m);
      key_sel_n = ~m[0];
      key_up_n  = ~m[1];
      key_dn_n  = ~m[2];
      key_en_n  = ~m[3];
   endtask

   task automatic press(input logic [3:0] m);
      @(negedge clk);
      drive(m);
      repeat (10) @(negedge clk);
      drive(4'b0000);
      repeat (10) @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_en", en, 0);
      chk("rst_freq", freq, 64);
      chk("rst_amp", amp, 1);
      chk("rst_phase", phase, 0);
      chk("rst_sel", sel, 0);
      chk("rst_upd", upd, 0);
      chk("rst_upd_cnt", upd_cnt, 0);

      // Latency: edge before posedge 1, register moves at posedge 7, upd at 8.
      @(negedge clk);
      key_up_n = 1'b0;
      repeat (6) @(posedge clk);
      #1 chk("lat_freq_c6", freq, 64);
      @(posedge clk);
      #1 chk("lat_freq_c7", freq, 80);
      chk("lat_upd_c7", upd, 0);
      @(posedge clk);
      #1 chk("lat_upd_c8", upd, 1);
      @(posedge clk);
      #1 chk("lat_upd_c9", upd, 0);
      repeat (100) @(negedge clk);
      chk("hold_freq", freq, 80);
      chk("hold_upd_cnt", upd_cnt, 1);
      key_up_n = 1'b1;
      repeat (20) @(negedge clk);

      u0 = upd_cnt;
      for (int i = 0; i < 15; i++) begin
         key_up_n = ~key_up_n;
         repeat (2) @(negedge clk);
      end
      key_up_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("bounce_freq", freq, 80);
      chk("bounce_upd", upd_cnt - u0, 0);

      u0 = upd_cnt;
      press(4'b1000);
      chk("en_toggle", en, 1);
      chk("en_upd", upd_cnt - u0, 1);

      press(4'b0001);
      press(4'b0001);
      chk("sel_phase", sel, 2);
      for (int i = 0; i < 300; i++) press(4'b0100);
      chk("phase_wrap", phase, 212);
      u0 = upd_cnt;
      press(4'b0110);
      chk("updn_phase", phase, 212);
      chk("updn_upd", upd_cnt - u0, 0);
      press(4'b0001);
      chk("sel_wrap", sel, 0);

      press(4'b0001);
      chk("sel_amp", sel, 1);
      u0 = upd_cnt;
      press(4'b0100);
      chk("amp_floor", amp, 1);
      chk("amp_floor_upd", upd_cnt - u0, 0);
      u0 = upd_cnt;
      for (int i = 0; i < 8; i++) press(4'b0010);
      chk("amp_ceil", amp, 7);
      chk("amp_ceil_upd", upd_cnt - u0, 6);

      press(4'b0001);
      press(4'b0001);
      chk("sel_freq", sel, 0);
      for (int i = 0; i < 250; i++) press(4'b0010);
      chk("freq_4080", freq, 4080);
      press(4'b0010);
      chk("freq_sat_hi", freq, 4095);
      u0 = upd_cnt;
      press(4'b0010);
      chk("freq_sat_hi2", freq, 4095);
      chk("freq_sat_hi_upd", upd_cnt - u0, 0);
      for (int i = 0; i < 255; i++) press(4'b0100);
      chk("freq_15", freq, 15);
      press(4'b0100);
      chk("freq_sat_lo", freq, 1);
      u0 = upd_cnt;
      press(4'b0100);
      chk("freq_sat_lo2", freq, 1);
      chk("freq_sat_lo_upd", upd_cnt - u0, 0);

      press(4'b0011);
      chk("selup_sel", sel, 1);
      chk("selup_freq", freq, 1);
      chk("selup_amp", amp, 7);

      @(negedge clk);
      key_up_n = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mrst_en", en, 0);
      chk("mrst_freq", freq, 64);
      chk("mrst_amp", amp, 1);
      chk("mrst_sel", sel, 0);
      chk("mrst_upd", upd, 0);
      repeat (3) @(negedge clk);
      u0 = upd_cnt;
      rst_n = 1'b1;
      repeat (15) @(negedge clk);
      chk("held_freq", freq, 80);
      chk("held_upd", upd_cnt - u0, 1);
      key_up_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("held_release", freq, 80);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
